// File: rtl/jtkunio_snd_cmd_rx_if.sv
// Main-to-sound command path: main CPU strobe/data, sound CPU latch read and
// the receiver status it sees.
interface jtkunio_snd_cmd_rx_if #(
    parameter int AW = 2
);
    logic          snd_cen;
    logic          main_wr;
    logic [7:0]    main_data;
    logic          latch_rd;
    logic          ovr_clr;
    logic [7:0]    dout;
    logic          irqn;
    logic [AW:0]   level;
    logic          overrun;

    modport master (
        output snd_cen, main_wr, main_data, latch_rd, ovr_clr,
        input  dout, irqn, level, overrun
    );

    modport slave (
        input  snd_cen, main_wr, main_data, latch_rd, ovr_clr,
        output dout, irqn, level, overrun
    );
endinterface

// File: rtl/jtkunio_snd_cmd_rx.sv
// Sound-side command receiver: queues main-CPU command bytes in a small FIFO,
// holds the sound IRQ low while commands wait, pops one per latch read.
module jtkunio_snd_cmd_rx #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int IRQ_GAP = 4
) (
    input  logic                  rst,
    input  logic                  clk,
    jtkunio_snd_cmd_rx_if.slave   bus
);
    localparam int GW = (IRQ_GAP > 1) ? $clog2(IRQ_GAP) : 1;
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(IRQ_GAP - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [7:0]    dout;
    logic          overrun;
    logic          wr_l, rd_l;
    state_t        state, state_nx;
    logic [GW-1:0] gap, gap_nx;

    logic push_req, pop, full, push, ovf;

    assign full     = cnt == FULL;
    assign push_req = bus.main_wr & ~wr_l;
    // read edge is tracked on cen ticks, so a held latch_rd pops only once
    assign pop      = bus.snd_cen & bus.latch_rd & ~rd_l & (cnt != '0);
    // a pop in the same clk frees the slot the incoming byte needs
    assign push     = push_req & (~full | pop);
    assign ovf      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.main_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            dout    <= 8'h00;
            overrun <= 1'b0;
            wr_l    <= 1'b1;  // no push for a strobe already high at release
            rd_l    <= 1'b0;
        end else begin
            wr_l <= bus.main_wr;
            if (bus.snd_cen) rd_l <= bus.latch_rd;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // head copy; holds the last popped byte once empty
            if (cnt != '0) dout <= mem[rd_ptr];
            if (ovf)              overrun <= 1'b1;
            else if (bus.ovr_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gap   <= '0;
        end else begin
            state <= state_nx;
            gap   <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gap_nx   = gap;
        case (state)
            IDLE: begin
                if (bus.snd_cen && cnt != '0) state_nx = ASSERT;
            end
            ASSERT: begin
                if (pop) begin
                    state_nx = GAP;
                    gap_nx   = GAP_LOAD;
                end
            end
            GAP: begin
                if (bus.snd_cen) begin
                    if (gap == '0) state_nx = IDLE;
                    else           gap_nx   = gap - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.irqn    = state != ASSERT;
    assign bus.dout    = dout;
    assign bus.level   = cnt;
    assign bus.overrun = overrun;
endmodule

// File: tb/tb_jtkunio_snd_cmd_rx.sv
// Bench for the sound command receiver: queue-based reference model checked
// every clk, directed scenarios with literal expectations, then random traffic.
module tb_jtkunio_snd_cmd_rx;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int IRQ_GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   cen_mode = 1'b0;
    bit   cen_val  = 1'b0;

    jtkunio_snd_cmd_rx_if #(.AW(AW)) bus();

    jtkunio_snd_cmd_rx #(.DEPTH(DEPTH), .AW(AW), .IRQ_GAP(IRQ_GAP)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // reference model: command queue plus tick-counted IRQ hold-off
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    bit   m_ovr  = 1'b0;
    bit   m_irq  = 1'b0;
    int   m_hold = 0;
    bit   m_wr_l = 1'b1;
    bit   m_rd_l = 1'b0;

    initial begin
        bit push_e, pop_e, ovf_e;
        int n;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_dout = 8'h00; m_ovr = 1'b0; m_irq = 1'b0; m_hold = 0;
                m_wr_l = 1'b1;  m_rd_l = 1'b0;
            end else begin
                n      = mq.size();
                push_e = bus.main_wr && !m_wr_l;
                pop_e  = bus.snd_cen && bus.latch_rd && !m_rd_l && n > 0;
                ovf_e  = push_e && n == DEPTH && !pop_e;
                if (n > 0) m_dout = mq[0];
                if (bus.snd_cen) begin
                    if (m_irq) begin
                        if (pop_e) begin m_irq = 1'b0; m_hold = IRQ_GAP; end
                    end else if (m_hold > 0) m_hold--;
                    else if (n > 0) m_irq = 1'b1;
                end
                if (pop_e) void'(mq.pop_front());
                if (push_e && !ovf_e) mq.push_back(bus.main_data);
                if (ovf_e) m_ovr = 1'b1;
                else if (bus.ovr_clr) m_ovr = 1'b0;
                m_wr_l = bus.main_wr;
                if (bus.snd_cen) m_rd_l = bus.latch_rd;
            end
        end
    end

    // compare process: outputs are all registered, sample on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            n_chk += 4;
            if (bus.level != (AW+1)'(mq.size())) begin
                n_fail++; $display("FAIL model_level: got %0d expected %0d", bus.level, mq.size());
            end
            if (bus.dout != m_dout) begin
                n_fail++; $display("FAIL model_dout: got %02h expected %02h", bus.dout, m_dout);
            end
            if (bus.irqn != !m_irq) begin
                n_fail++; $display("FAIL model_irqn: got %0b expected %0b", bus.irqn, !m_irq);
            end
            if (bus.overrun != m_ovr) begin
                n_fail++; $display("FAIL model_overrun: got %0b expected %0b", bus.overrun, m_ovr);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        bus.snd_cen = cen_mode ? cen_val : ($urandom_range(0, 2) == 0);
    endtask

    // run until n cen ticks have been presented, then let the last one land
    task automatic ticks(input int n);
        int c = 0;
        int k = 0;
        while (c < n && k < 1000) begin
            step();
            if (bus.snd_cen) c++;
            k++;
        end
        if (c < n) chk("cen_tick_timeout", c, n);
        step();
    endtask

    task automatic push(input logic [7:0] b, input int hold);
        step();
        bus.main_wr = 1'b1; bus.main_data = b;
        repeat (hold) step();
        bus.main_wr = 1'b0;
        step();
    endtask

    task automatic rd_cmd();
        bus.latch_rd = 1'b1;
        ticks(1);
        bus.latch_rd = 1'b0;
        ticks(1);
    endtask

    task automatic wait_irq();
        int k = 0;
        while (bus.irqn && k < 500) begin step(); k++; end
        chk("irq_assert_timeout", int'(bus.irqn), 0);
    endtask

    initial begin
        bus.snd_cen = 1'b0; bus.main_wr = 1'b0; bus.main_data = 8'h00;
        bus.latch_rd = 1'b0; bus.ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_dout", int'(bus.dout), 8'h00);
        chk("rst_irqn", int'(bus.irqn), 1);
        chk("rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        step();

        // single held command
        push(8'h5A, 10);
        chk("single_level", int'(bus.level), 1);
        chk("single_dout", int'(bus.dout), 8'h5A);
        ticks(1);
        chk("single_irqn_low", int'(bus.irqn), 0);
        rd_cmd();
        chk("single_level_after", int'(bus.level), 0);
        for (int i = 0; i < IRQ_GAP + 3; i++) begin
            ticks(1);
            chk("single_irqn_high", int'(bus.irqn), 1);
        end

        // three back to back, read in order
        push(8'h01, 2); push(8'h02, 2); push(8'h03, 2);
        chk("three_level", int'(bus.level), 3);
        for (int i = 0; i < 3; i++) begin
            wait_irq();
            chk("three_dout", int'(bus.dout), i + 1);
            rd_cmd();
        end
        chk("three_empty", int'(bus.level), 0);

        // overflow: fifth byte lost
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 2);
        chk("ovf_level", int'(bus.level), 4);
        chk("ovf_flag", int'(bus.overrun), 1);
        step(); bus.ovr_clr = 1'b1; step(); bus.ovr_clr = 1'b0; step();
        chk("ovf_clr", int'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) begin
            wait_irq();
            chk("ovf_dout", int'(bus.dout), 8'h10 + i);
            rd_cmd();
        end
        chk("ovf_drained", int'(bus.level), 0);

        // held latch_rd pops exactly once
        push(8'h20, 2); push(8'h21, 2);
        bus.latch_rd = 1'b1;
        ticks(6);
        bus.latch_rd = 1'b0;
        ticks(1);
        chk("held_rd_level", int'(bus.level), 1);
        chk("held_rd_dout", int'(bus.dout), 8'h21);
        rd_cmd();

        // full FIFO, push and pop in the same clk
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 2);
        cen_mode = 1'b1; cen_val = 1'b0;
        step(); bus.latch_rd = 1'b1;
        step();
        cen_val = 1'b1;
        step(); bus.main_wr = 1'b1; bus.main_data = 8'hB5;
        cen_val = 1'b0;
        step(); bus.main_wr = 1'b0;
        step(); step();
        chk("full_pp_level", int'(bus.level), 4);
        chk("full_pp_overrun", int'(bus.overrun), 0);
        cen_mode = 1'b0;
        bus.latch_rd = 1'b0;
        ticks(1);
        for (int i = 0; i < 4; i++) begin
            wait_irq();
            chk("full_pp_dout", int'(bus.dout), (i < 3) ? (8'hA1 + i) : 8'hB5);
            rd_cmd();
        end

        // reset mid-operation, strobe held across release
        push(8'h30, 2); push(8'h31, 2); push(8'h32, 2);
        wait_irq();
        #2 rst = 1'b1;
        bus.main_wr = 1'b1; bus.main_data = 8'h77;
        #1;
        chk("midrst_level", int'(bus.level), 0);
        chk("midrst_irqn", int'(bus.irqn), 1);
        chk("midrst_dout", int'(bus.dout), 8'h00);
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        chk("rst_release_nopush", int'(bus.level), 0);
        bus.main_wr = 1'b0;
        step();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) begin
                if (!bus.main_wr) bus.main_data = 8'($urandom);
                bus.main_wr = ~bus.main_wr;
            end
            if ($urandom_range(0, 5) == 0) bus.latch_rd = ~bus.latch_rd;
            bus.ovr_clr = ($urandom_range(0, 30) == 0);
        end
        bus.ovr_clr = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
